// File: rtl/mem_boot_loader_if.sv
// Host byte stream, memory write port and core-reset/status signals of the boot loader.
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready; the host
// keeps rx_data stable while rx_valid is high and rx_valid does not depend on rx_ready.
interface mem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  logic [2:0]        state;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rst, done, err, state
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rst, done, err, state
  );
endinterface

// File: rtl/mem_boot_loader.sv
// Framed byte-stream loader: writes little-endian words into prog/data memory and
// holds the core in reset until a release command arrives.
module mem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              rst,
  mem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR0 = 3'd1,
    ADDR1 = 3'd2,
    CNT0  = 3'd3,
    CNT1  = 3'd4,
    DATA  = 3'd5,
    CSUM  = 3'd6,
    RUN   = 3'd7
  } state_t;

  localparam logic [7:0]        CMD_PROG = 8'hA5;
  localparam logic [7:0]        CMD_DATA = 8'h5A;
  localparam logic [7:0]        CMD_RUN  = 8'hF0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [7:0]        lo_byte;
  logic [7:0]        csum_acc;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_word;
  logic              accept;
  logic              is_load;
  logic [7:0]        d;

  assign d         = bus.rx_data;
  assign accept    = bus.rx_valid && bus.rx_ready;
  assign is_load   = (d == CMD_PROG) || (d == CMD_DATA);
  assign bus.state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lo_byte       <= '0;
      csum_acc      <= '0;
      addr          <= '0;
      cnt           <= '0;
      byte_idx      <= '0;
      asm_word      <= '0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_sel   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.core_rst  <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.mem_we   <= 1'b0;
      bus.done     <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, RUN: begin
            if (is_load) begin
              bus.mem_sel  <= (d == CMD_DATA);
              bus.err      <= 1'b0;
              bus.core_rst <= 1'b1;
              csum_acc     <= d;
              state        <= ADDR0;
            end else if (d == CMD_RUN) begin
              bus.core_rst <= 1'b0;
              state        <= RUN;
            end else if (state == IDLE) begin
              // Junk while the core is running is dropped silently.
              bus.err <= 1'b1;
            end
          end
          ADDR0: begin
            lo_byte  <= d;
            csum_acc <= csum_acc + d;
            state    <= ADDR1;
          end
          ADDR1: begin
            addr     <= ADDR_W'({d, lo_byte});
            csum_acc <= csum_acc + d;
            state    <= CNT0;
          end
          CNT0: begin
            lo_byte  <= d;
            csum_acc <= csum_acc + d;
            state    <= CNT1;
          end
          CNT1: begin
            cnt      <= {d, lo_byte};
            csum_acc <= csum_acc + d;
            byte_idx <= 2'd0;
            state    <= ({d, lo_byte} != 16'd0) ? DATA : CSUM;
          end
          DATA: begin
            csum_acc <= csum_acc + d;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= d;
              2'd1: asm_word[15:8]  <= d;
              2'd2: asm_word[23:16] <= d;
              default: begin
                // Separate write-out register lets the next word start immediately.
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= {d, asm_word};
                bus.mem_addr  <= addr;
                addr          <= addr + ADDR_ONE;
                cnt           <= cnt - 16'd1;
                if (cnt == 16'd1) state <= CSUM;
              end
            endcase
          end
          CSUM: begin
            if (d == csum_acc) bus.done <= 1'b1;
            else               bus.err  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
